// File: rtl/console_writer.sv
// Text console writer: places characters and control codes from a valid/ready stream
// into character/attribute RAM at a wrapping cursor, with row and full-screen clears.
module console_writer #(
    parameter int         COLS         = 80,
    parameter int         ROWS         = 30,
    parameter logic [7:0] FILL_CHAR    = 8'h20,
    parameter logic [7:0] DEFAULT_ATTR = 8'h0F
) (
    input  logic        clk_pixel,
    input  logic        reset,
    input  logic [7:0]  char_in,
    input  logic [7:0]  attr_in,
    input  logic        char_valid,
    output logic        char_ready,
    output logic [12:0] ram_address,
    output logic [7:0]  ram_char_data,
    output logic [7:0]  ram_attr_data,
    output logic        ram_char_we,
    output logic        ram_attr_we,
    output logic [6:0]  cursor_col,
    output logic [5:0]  cursor_row,
    output logic [1:0]  state_dbg
);
    // Handshake: a character transfers on a rising clk_pixel edge where char_valid and
    // char_ready are both high; char_ready is high only in IDLE and nothing is buffered.

    typedef enum logic [1:0] {IDLE, WRITE, CLR_ROW, CLR_SCREEN} state_t;

    localparam logic [6:0] LAST_COL = 7'(COLS - 1);
    localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);

    state_t      state, state_next;
    logic [6:0]  col_q, clr_col;
    logic [5:0]  row_q, clr_row;
    logic [7:0]  op_attr, wr_char;
    logic [12:0] wr_addr;
    logic        wr_en, row_clear_pending;
    logic        is_bs, is_lf, is_ff, is_cr;
    logic [6:0]  col_dec, col_inc;
    logic [5:0]  row_next;
    logic        we;

    assign is_bs    = (char_in == 8'h08);
    assign is_lf    = (char_in == 8'h0A);
    assign is_ff    = (char_in == 8'h0C);
    assign is_cr    = (char_in == 8'h0D);
    assign col_dec  = col_q - 7'd1;
    assign col_inc  = col_q + 7'd1;
    assign row_next = (row_q == LAST_ROW) ? 6'd0 : row_q + 6'd1;

    assign ram_char_we = we;
    assign ram_attr_we = we;
    assign cursor_col  = col_q;
    assign cursor_row  = row_q;
    assign state_dbg   = state;

    always_ff @(posedge clk_pixel) begin
        if (reset) state <= CLR_SCREEN;
        else       state <= state_next;
    end

    always_comb begin
        state_next    = state;
        char_ready    = 1'b0;
        we            = 1'b0;
        ram_address   = 13'd0;
        ram_char_data = 8'd0;
        ram_attr_data = 8'd0;
        unique case (state)
            IDLE: begin
                char_ready = 1'b1;
                if (char_valid) begin
                    if (is_ff)      state_next = CLR_SCREEN;
                    else if (is_lf) state_next = CLR_ROW;
                    else            state_next = WRITE;
                end
            end
            WRITE: begin
                we            = wr_en;
                ram_address   = wr_addr;
                ram_char_data = wr_char;
                ram_attr_data = op_attr;
                state_next    = row_clear_pending ? CLR_ROW : IDLE;
            end
            CLR_ROW: begin
                we            = 1'b1;
                ram_address   = {row_q, clr_col};
                ram_char_data = FILL_CHAR;
                ram_attr_data = op_attr;
                if (clr_col == LAST_COL) state_next = IDLE;
            end
            CLR_SCREEN: begin
                we            = 1'b1;
                ram_address   = {clr_row, clr_col};
                ram_char_data = FILL_CHAR;
                ram_attr_data = op_attr;
                if (clr_col == LAST_COL && clr_row == LAST_ROW) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Reset silences the RAM port in the same cycle it is seen.
        if (reset) begin
            state_next    = CLR_SCREEN;
            char_ready    = 1'b0;
            we            = 1'b0;
            ram_address   = 13'd0;
            ram_char_data = 8'd0;
            ram_attr_data = 8'd0;
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            col_q             <= 7'd0;
            row_q             <= 6'd0;
            clr_col           <= 7'd0;
            clr_row           <= 6'd0;
            op_attr           <= DEFAULT_ATTR;
            wr_en             <= 1'b0;
            wr_char           <= 8'd0;
            wr_addr           <= 13'd0;
            row_clear_pending <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (char_valid) begin
                    op_attr           <= attr_in;
                    clr_col           <= 7'd0;
                    clr_row           <= 6'd0;
                    wr_en             <= 1'b0;
                    wr_char           <= FILL_CHAR;
                    wr_addr           <= {row_q, col_q};
                    row_clear_pending <= 1'b0;
                    if (is_ff) begin
                        col_q <= 7'd0;
                        row_q <= 6'd0;
                    end else if (is_lf) begin
                        col_q <= 7'd0;
                        row_q <= row_next;
                    end else if (is_cr) begin
                        col_q <= 7'd0;
                    end else if (is_bs) begin
                        if (col_q != 7'd0) begin
                            col_q   <= col_dec;
                            wr_en   <= 1'b1;
                            wr_addr <= {row_q, col_dec};
                        end
                    end else begin
                        wr_en   <= 1'b1;
                        wr_char <= char_in;
                        // The write address keeps the old cursor; the cursor moves now.
                        if (col_q == LAST_COL) begin
                            col_q             <= 7'd0;
                            row_q             <= row_next;
                            row_clear_pending <= 1'b1;
                        end else begin
                            col_q <= col_inc;
                        end
                    end
                end
                CLR_ROW: clr_col <= clr_col + 7'd1;
                CLR_SCREEN: begin
                    if (clr_col == LAST_COL) begin
                        clr_col <= 7'd0;
                        clr_row <= clr_row + 6'd1;
                    end else begin
                        clr_col <= clr_col + 7'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_console_writer.sv
// Bench for console_writer: expected RAM writes go into a queue as stimulus is issued,
// and a monitor pops and compares every write the DUT presents.
module tb_console_writer;
    logic        clk_pixel = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  char_in = 8'd0;
    logic [7:0]  attr_in = 8'd0;
    logic        char_valid = 1'b0;
    logic        char_ready;
    logic [12:0] ram_address;
    logic [7:0]  ram_char_data, ram_attr_data;
    logic        ram_char_we, ram_attr_we;
    logic [6:0]  cursor_col;
    logic [5:0]  cursor_row;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;
    int write_count = 0;
    int mrow = 0;
    int mcol = 0;
    logic [28:0] exp_q[$];

    console_writer dut (
        .clk_pixel(clk_pixel), .reset(reset), .char_in(char_in), .attr_in(attr_in),
        .char_valid(char_valid), .char_ready(char_ready), .ram_address(ram_address),
        .ram_char_data(ram_char_data), .ram_attr_data(ram_attr_data),
        .ram_char_we(ram_char_we), .ram_attr_we(ram_attr_we),
        .cursor_col(cursor_col), .cursor_row(cursor_row), .state_dbg(state_dbg)
    );

    always #5 clk_pixel = ~clk_pixel;

    function automatic logic [28:0] entry(int r, int c, logic [7:0] ch, logic [7:0] at);
        return {6'(r), 7'(c), ch, at};
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every asserted strobe must match the oldest expected write.
    always @(negedge clk_pixel) begin
        if (ram_char_we || ram_attr_we) begin
            logic [28:0] e;
            write_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%0h char=%0h attr=%0h", ram_address, ram_char_data, ram_attr_data);
            end else begin
                e = exp_q.pop_front();
                if ({ram_address, ram_char_data, ram_attr_data} !== e || ram_char_we !== ram_attr_we ||
                    ram_address[6:0] >= 7'd80 || ram_address[12:7] >= 6'd30) begin
                    errors++;
                    $display("FAIL write_%0d actual=%0h/%0h/%0h we=%b%b expected=%0h/%0h/%0h", write_count,
                             ram_address, ram_char_data, ram_attr_data, ram_char_we, ram_attr_we,
                             e[28:16], e[15:8], e[7:0]);
                end
            end
        end
    end

    task automatic push_row_clear(int r, logic [7:0] at);
        for (int c = 0; c < 80; c++) exp_q.push_back(entry(r, c, 8'h20, at));
    endtask

    task automatic push_screen_clear(logic [7:0] at, int n);
        for (int i = 0; i < n; i++) exp_q.push_back(entry(i / 80, i % 80, 8'h20, at));
    endtask

    task automatic wait_ready(string name, int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk_pixel); #1;
            n++;
        end while (!char_ready && n < budget);
        if (!char_ready) check({name, "_ready_timeout"}, 0, 1);
    endtask

    task automatic send(logic [7:0] ch, logic [7:0] at);
        wait_ready("send", 3000);
        char_in = ch;
        attr_in = at;
        char_valid = 1'b1;
        @(posedge clk_pixel); #1;
        char_valid = 1'b0;
    endtask

    // Expected effect of one accepted code on the queue and the model cursor.
    task automatic model_send(logic [7:0] ch, logic [7:0] at);
        if (ch == 8'h0A) begin
            mcol = 0; mrow = (mrow + 1) % 30;
            push_row_clear(mrow, at);
        end else if (ch == 8'h0D) begin
            mcol = 0;
        end else if (ch == 8'h08) begin
            if (mcol > 0) begin
                mcol--;
                exp_q.push_back(entry(mrow, mcol, 8'h20, at));
            end
        end else begin
            exp_q.push_back(entry(mrow, mcol, ch, at));
            if (mcol == 79) begin
                mcol = 0; mrow = (mrow + 1) % 30;
                push_row_clear(mrow, at);
            end else mcol++;
        end
    endtask

    task automatic do_send(logic [7:0] ch, logic [7:0] at);
        model_send(ch, at);
        send(ch, at);
    endtask

    task automatic check_cursor(string name, int r, int c);
        check({name, "_row"}, int'(cursor_row), r);
        check({name, "_col"}, int'(cursor_col), c);
    endtask

    task automatic release_and_count(string name);
        int n;
        @(posedge clk_pixel); #1;
        reset = 1'b0;
        n = 0;
        do begin
            @(negedge clk_pixel); #1;
            n++;
        end while (!char_ready && n < 3000);
        check({name, "_ready_cycle"}, n, 2401);
        check({name, "_queue_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        int base;
        // Reset state
        repeat (3) @(posedge clk_pixel);
        @(negedge clk_pixel); #1;
        check("reset_we", int'(ram_char_we | ram_attr_we), 0);
        check("reset_ready", int'(char_ready), 0);
        check("reset_addr", int'(ram_address), 0);
        check_cursor("reset_cursor", 0, 0);

        push_screen_clear(8'h0F, 2400);
        release_and_count("init_clear");

        // Plain character at (0,0); ready low for exactly one cycle
        do_send(8'h41, 8'h1E);
        @(negedge clk_pixel); #1;
        check_cursor("char_a", 0, 1);
        check("char_a_ready_low", int'(char_ready), 0);
        @(negedge clk_pixel); #1;
        check("char_a_ready_back", int'(char_ready), 1);

        // Walk to (29,79) and wrap into row 0
        do_send(8'h0D, 8'h07);
        for (int i = 0; i < 29; i++) do_send(8'h0A, 8'h07);
        for (int i = 0; i < 79; i++) do_send(8'(8'h30 + i % 10), 8'h07);
        wait_ready("at_29_79", 100);
        check_cursor("at_29_79", 29, 79);
        do_send(8'h42, 8'h2C);
        @(negedge clk_pixel); #1;
        check_cursor("wrap_cursor", 0, 0);
        wait_ready("wrap_clear", 200);
        check("wrap_queue", exp_q.size(), 0);

        // Backspace / carriage return at (5,10)
        for (int i = 0; i < 5; i++) do_send(8'h0A, 8'h07);
        for (int i = 0; i < 10; i++) do_send(8'h61, 8'h07);
        wait_ready("at_5_10", 100);
        check_cursor("at_5_10", 5, 10);
        do_send(8'h08, 8'h33);
        wait_ready("bs", 10);
        check_cursor("bs", 5, 9);
        do_send(8'h0D, 8'h33);
        wait_ready("cr", 10);
        check_cursor("cr", 5, 0);
        do_send(8'h08, 8'h33);
        wait_ready("bs_col0", 10);
        check_cursor("bs_col0", 5, 0);

        // Hold valid through a row clear; the next char lands at (6,0)
        model_send(8'h0A, 8'h44);
        model_send(8'h5A, 8'h5A);
        wait_ready("hold", 10);
        char_in = 8'h0A; attr_in = 8'h44; char_valid = 1'b1;
        @(posedge clk_pixel); #1;
        char_in = 8'h5A; attr_in = 8'h5A;
        wait_ready("hold_clear", 200);
        @(posedge clk_pixel); #1;
        char_valid = 1'b0;
        wait_ready("hold_done", 10);
        check_cursor("hold", 6, 1);
        check("hold_queue", exp_q.size(), 0);

        // Form feed from (12,40), aborted by reset at write 1000
        do_send(8'h0D, 8'h07);
        for (int i = 0; i < 6; i++) do_send(8'h0A, 8'h07);
        for (int i = 0; i < 40; i++) do_send(8'h62, 8'h07);
        wait_ready("at_12_40", 100);
        check_cursor("at_12_40", 12, 40);
        base = write_count;
        push_screen_clear(8'h70, 1000);
        send(8'h0C, 8'h70);
        @(negedge clk_pixel); #1;
        check_cursor("ff_cursor", 0, 0);
        check("ff_ready_low", int'(char_ready), 0);
        for (int i = 0; i < 1100 && write_count < base + 1000; i++) begin
            @(negedge clk_pixel); #1;
        end
        check("ff_writes_before_reset", write_count - base, 1000);
        @(posedge clk_pixel); #1;
        reset = 1'b1;
        @(negedge clk_pixel); #1;
        check("abort_we", int'(ram_char_we | ram_attr_we), 0);
        check("abort_ready", int'(char_ready), 0);
        check("abort_queue", exp_q.size(), 0);
        push_screen_clear(8'h0F, 2400);
        repeat (2) @(posedge clk_pixel);
        release_and_count("restart_clear");
        check_cursor("restart", 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/console_writer.md
CONSOLE_WRITER -- requirements
Module: console_writer

Interface
REQ-001: Parameter COLS, 80, visible text columns per row (col field 7 bits).
REQ-002: Parameter ROWS, 30, visible text rows (row field 6 bits).
REQ-003: Parameter FILL_CHAR, 8'h20, codepoint written by all clear operations.
REQ-004: Parameter DEFAULT_ATTR, 8'h0F, attribute used by the reset-time screen clear.
REQ-005: CLK  in  1  single clock for all logic; one clock domain.
REQ-006: RESET  in  1  synchronous, active-high reset.
REQ-007: CHAR_IN  in  8  codepoint or control code to place at the cursor.
REQ-008: ATTR_IN  in  8  attribute paired with CHAR_IN; sampled on acceptance.
REQ-009: CHAR_VALID  in  1  CHAR_IN/ATTR_IN valid.
REQ-010: CHAR_READY  out  1  block can accept; transfer occurs when CHAR_VALID and CHAR_READY are both high at a rising CLK edge.
REQ-011: RAM_ADDRESS  out  13  write address {row[5:0], col[6:0]}, matching the display read-side layout.
REQ-012: RAM_CHAR_DATA  out  8  codepoint to write.
REQ-013: RAM_ATTR_DATA  out  8  attribute to write.
REQ-014: RAM_CHAR_WE / RAM_ATTR_WE  out  1 each  write strobes, always asserted together, one cycle per write.
REQ-015: CURSOR_COL  out  7 / CURSOR_ROW  out  6  current cursor position.

Function
REQ-016: States SHALL be IDLE, WRITE, CLR_ROW, CLR_SCREEN; CHAR_READY SHALL be high only in IDLE.
REQ-017: Accepted codepoint not in {8'h08, 8'h0A, 8'h0C, 8'h0D} SHALL be written at cursor in the cycle after acceptance (WRITE state, one write), then cursor advances one column.
REQ-018: Column advance from COLS-1 SHALL set col=0, row=row+1 (ROWS-1 wraps to 0), then enter CLR_ROW for the new row.
REQ-019: 8'h0A (LF) SHALL set col=0, advance row with same wrap, then CLR_ROW; no character written.
REQ-020: 8'h0D (CR) SHALL set col=0 with no write; block returns to IDLE after one cycle.
REQ-021: 8'h08 (BS) with col>0 SHALL decrement col and write FILL_CHAR/ATTR_IN at the new position; with col=0 it SHALL do nothing except the one-cycle WRITE state.
REQ-022: 8'h0C (FF) SHALL enter CLR_SCREEN using the sampled ATTR_IN, then set cursor to (0,0).
REQ-023: CLR_ROW SHALL issue exactly COLS consecutive writes (one per cycle, col 0..COLS-1) of FILL_CHAR with the sampled attribute on the current row, then return to IDLE.
REQ-024: CLR_SCREEN SHALL issue exactly COLS*ROWS consecutive writes, row-major from (0,0) to (ROWS-1,COLS-1), then return to IDLE.
REQ-025: Addresses with col>=COLS or row>=ROWS SHALL never be written.
REQ-026: CURSOR_COL/ROW SHALL reflect the post-operation position from the cycle after acceptance onward.
REQ-027: CHAR_VALID while CHAR_READY low SHALL be ignored; no input is buffered.

Reset
REQ-028: While RESET high: write strobes 0, RAM_ADDRESS/data 0, CHAR_READY 0, cursor (0,0), state forced to CLR_SCREEN-pending.
REQ-029: First cycle after RESET falls SHALL begin a full CLR_SCREEN with DEFAULT_ATTR; CHAR_READY rises the cycle after the final write (2400 writes at defaults).
REQ-030: RESET asserted mid-operation (any state) SHALL abort it immediately and restart per REQ-028/029.

Verification
REQ-031: Release reset -> exactly 2400 writes of 8'h20/8'h0F covering rows 0-29, cols 0-79, no address with col>=80; CHAR_READY high on cycle 2401.
REQ-032: Send 'A'(8'h41)/attr 8'h1E at (0,0) -> one write addr 13'h0000 data 8'h41/8'h1E, cursor (0,1), CHAR_READY low exactly one cycle.
REQ-033: Cursor at (29,79), send 8'h42 -> write at {6'd29,7'd79}, then 80 clear writes on row 0, cursor (0,0).
REQ-034: Cursor (5,10): BS -> write 8'h20 at {6'd5,7'd9}, cursor (5,9); CR -> no write, cursor (5,0); BS at col 0 -> no write, cursor unchanged.
REQ-035: Send FF with attr 8'h70 at (12,40) -> 2400 writes attr 8'h70, cursor (0,0); assert RESET at write 1000 -> strobes drop, full clear restarts with 8'h0F.
REQ-036: Hold CHAR_VALID high through a CLR_ROW -> no acceptance until CHAR_READY returns; next char written at (row,0).
